// File: rtl/wb_sched_pkg.sv
// Shared types for the writeback slot scheduler: table depth, slot record, owner id.
// Owner ids are binary and sized for the default number of fixed-latency ports.
// No logic lives here.
package wb_sched_pkg;

    localparam int WbSchedDepth = 16;
    localparam int WbFixNum     = 3;
    localparam int WbOwnerW     = $clog2(WbFixNum);

    typedef logic [WbOwnerW-1:0] WbOwner_t;

    typedef struct packed {
        logic     valid;
        WbOwner_t owner;
    } WbSlot_t;

endpackage

// File: rtl/wb_sched_rr.sv
// Round-robin arbiter over active-low requests with a registered next-start pointer.
// Latency: combinational grant in the request cycle; pointer updates on the clock edge.
// Backpressure: en_i low suppresses all grants and holds the pointer.
module wb_sched_rr #(
    parameter int VAR_NUM = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic [VAR_NUM-1:0] req_n_i,
    output logic [VAR_NUM-1:0] gnt_n_o
);

    localparam int PW = (VAR_NUM > 1) ? $clog2(VAR_NUM) : 1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [VAR_NUM-1:0] gnt;
    logic               found;

    // First pass searches from the pointer upward; second pass wraps to index 0.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        for (int i = 0; i < VAR_NUM; i++) begin
            if (en_i && !found && !req_n_i[i] && i >= int'(ptr_q)) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
                ptr_d  = (i == VAR_NUM - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < VAR_NUM; i++) begin
            if (en_i && !found && !req_n_i[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
                ptr_d  = (i == VAR_NUM - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_n_o = ~gnt;

endmodule

// File: rtl/wb_sched.sv
// CDB writeback scheduler: fixed units reserve future slots, variable units take free current slots.
// Latency: acks are combinational; a fixed grant with latency L owns the bus L cycles later.
// Backpressure: denied requesters hold their request; WB_SCHED_AGING_EN blocks reservations for starved variable units.
module wb_sched
    import wb_sched_pkg::*;
#(
    parameter int DEPTH   = WbSchedDepth,
    parameter int FIX_NUM = WbFixNum,
    parameter int VAR_NUM = 3,
    parameter int STARVE  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [FIX_NUM-1:0]               iss_req_,
    input  logic [FIX_NUM*$clog2(DEPTH)-1:0] iss_lat,
    output logic [FIX_NUM-1:0]               iss_ack_,
    output logic                             lat_err,
    input  logic [VAR_NUM-1:0]               var_req_,
    output logic [VAR_NUM-1:0]               var_ack_,
    output logic [FIX_NUM+VAR_NUM-1:0]       wb_sel_,
    output logic                             wb_e_
);

    localparam int LW = $clog2(DEPTH);

    WbSlot_t                    tab_q [DEPTH];
    WbSlot_t                    tab_d [DEPTH];
    logic                       lat_err_q, lat_err_d;
    logic                       starve;
    logic [LW-1:0]              lat;
    logic [DEPTH-1:0]           claim;
    logic [FIX_NUM-1:0]         iss_ack;
    logic [VAR_NUM-1:0]         var_gnt_n;
    logic [FIX_NUM+VAR_NUM-1:0] sel;

    // Entry k is bus cycle now+k, so a grant at latency L lands in next-state entry L-1.
    always_comb begin
        lat       = '0;
        claim     = '0;
        iss_ack   = '0;
        lat_err_d = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            tab_d[k] = tab_q[k+1];
        end
        tab_d[DEPTH-1] = '0;
        for (int p = 0; p < FIX_NUM; p++) begin
            lat = iss_lat[p*LW +: LW];
            if (!iss_req_[p]) begin
                if (lat == '0 || 32'(lat) >= DEPTH) begin
                    lat_err_d = 1'b1;
                end else if (!flush && !starve && !tab_q[lat].valid && !claim[lat]) begin
                    iss_ack[p]        = 1'b1;
                    claim[lat]        = 1'b1;
                    tab_d[lat - 1'b1] = '{valid: 1'b1, owner: WbOwner_t'(p)};
                end
            end
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                tab_d[k] = '0;
            end
        end
    end

    wb_sched_rr #(
        .VAR_NUM (VAR_NUM)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .en_i    (!tab_q[0].valid),
        .req_n_i (var_req_),
        .gnt_n_o (var_gnt_n)
    );

    always_comb begin
        sel = '0;
        if (tab_q[0].valid) begin
            for (int p = 0; p < FIX_NUM; p++) begin
                if (tab_q[0].owner == WbOwner_t'(p)) begin
                    sel[p] = 1'b1;
                end
            end
        end else begin
            sel[FIX_NUM +: VAR_NUM] = ~var_gnt_n;
        end
    end

`ifdef WB_SCHED_AGING_EN
    localparam int CW = $clog2(STARVE + 1);

    logic [CW-1:0] age_q [VAR_NUM];
    logic [CW-1:0] age_d [VAR_NUM];

    // A saturated counter holds off reservations until that requester wins a free slot.
    always_comb begin
        starve = 1'b0;
        for (int i = 0; i < VAR_NUM; i++) begin
            if (age_q[i] >= CW'(STARVE)) begin
                starve = 1'b1;
            end
            if (!var_req_[i] && var_gnt_n[i]) begin
                age_d[i] = (age_q[i] >= CW'(STARVE)) ? age_q[i] : age_q[i] + 1'b1;
            end else begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < VAR_NUM; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic unused_starve;

    assign starve        = 1'b0;
    assign unused_starve = (STARVE != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                tab_q[k] <= '0;
            end
            lat_err_q <= 1'b0;
        end else begin
            tab_q     <= tab_d;
            lat_err_q <= lat_err_d;
        end
    end

    assign iss_ack_ = ~iss_ack;
    assign var_ack_ = var_gnt_n;
    assign wb_sel_  = ~sel;
    assign wb_e_    = ~|sel;
    assign lat_err  = lat_err_q;

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_wb_sched;

    localparam int DEPTH   = 16;
    localparam int FIX_NUM = 3;
    localparam int VAR_NUM = 3;
    localparam int STARVE  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [2:0]  iss_req_;
    logic [11:0] iss_lat;
    logic [2:0]  iss_ack_;
    logic        lat_err;
    logic [2:0]  var_req_;
    logic [2:0]  var_ack_;
    logic [5:0]  wb_sel_;
    logic        wb_e_;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [2:0] rq;
        logic [3:0] l0, l1, l2;
        logic [2:0] vq;
        logic       fl;
        logic [2:0] ack;
        logic [2:0] vack;
        logic [5:0] sel;
        logic       e;
        logic       le;
    } vec_t;

    vec_t tbl [20];

    always #5 clk = ~clk;

    wb_sched #(
        .DEPTH   (DEPTH),
        .FIX_NUM (FIX_NUM),
        .VAR_NUM (VAR_NUM),
        .STARVE  (STARVE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .iss_req_ (iss_req_),
        .iss_lat  (iss_lat),
        .iss_ack_ (iss_ack_),
        .lat_err  (lat_err),
        .var_req_ (var_req_),
        .var_ack_ (var_ack_),
        .wb_sel_  (wb_sel_),
        .wb_e_    (wb_e_)
    );

    function automatic vec_t mk(input logic [2:0] rq, input logic [3:0] l0, input logic [3:0] l1,
                                input logic [3:0] l2, input logic [2:0] vq, input logic fl,
                                input logic [2:0] ack, input logic [2:0] vack, input logic [5:0] sel,
                                input logic e, input logic le);
        vec_t v;
        v.rq = rq; v.l0 = l0; v.l1 = l1; v.l2 = l2; v.vq = vq; v.fl = fl;
        v.ack = ack; v.vack = vack; v.sel = sel; v.e = e; v.le = le;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [2:0] rq, input logic [3:0] l0, input logic [3:0] l1,
                       input logic [3:0] l2, input logic [2:0] vq, input logic fl);
        iss_req_ = rq;
        iss_lat  = {l2, l1, l0};
        var_req_ = vq;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(3'b111, 4'd0, 4'd0, 4'd0, 3'b111, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        //            rq      l0 l1 l2 vq      fl    ack     vack    sel        e     le
        tbl[0]  = mk(3'b110, 3, 0, 0, 3'b111, 1'b0, 3'b110, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[1]  = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[2]  = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[3]  = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111110, 1'b0, 1'b0);
        tbl[4]  = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[5]  = mk(3'b100, 2, 2, 0, 3'b111, 1'b0, 3'b110, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[6]  = mk(3'b101, 0, 1, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[7]  = mk(3'b101, 0, 1, 0, 3'b111, 1'b0, 3'b101, 3'b111, 6'b111110, 1'b0, 1'b0);
        tbl[8]  = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111101, 1'b0, 1'b0);
        tbl[9]  = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[10] = mk(3'b100, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[11] = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b1);
        tbl[12] = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[13] = mk(3'b010, 4, 0, 1, 3'b111, 1'b0, 3'b010, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[14] = mk(3'b101, 0, 1, 0, 3'b111, 1'b1, 3'b111, 3'b111, 6'b111011, 1'b0, 1'b0);
        tbl[15] = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[16] = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[17] = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);
        tbl[18] = mk(3'b111, 0, 0, 0, 3'b110, 1'b1, 3'b111, 3'b110, 6'b110111, 1'b0, 1'b0);
        tbl[19] = mk(3'b111, 0, 0, 0, 3'b111, 1'b0, 3'b111, 3'b111, 6'b111111, 1'b1, 1'b0);

        do_reset();
        #4;
        chk("rst.iss_ack_", 32'(iss_ack_), 32'h7);
        chk("rst.var_ack_", 32'(var_ack_), 32'h7);
        chk("rst.wb_sel_",  32'(wb_sel_),  32'h3f);
        chk("rst.wb_e_",    32'(wb_e_),    32'h1);
        chk("rst.lat_err",  32'(lat_err),  32'h0);
        tick();

        for (int i = 0; i < 20; i++) begin
            drv(tbl[i].rq, tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].vq, tbl[i].fl);
            #4;
            chk($sformatf("tbl%0d.iss_ack_", i), 32'(iss_ack_), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d.var_ack_", i), 32'(var_ack_), 32'(tbl[i].vack));
            chk($sformatf("tbl%0d.wb_sel_", i),  32'(wb_sel_),  32'(tbl[i].sel));
            chk($sformatf("tbl%0d.wb_e_", i),    32'(wb_e_),    32'(tbl[i].e));
            chk($sformatf("tbl%0d.lat_err", i),  32'(lat_err),  32'(tbl[i].le));
            tick();
        end

        // Round-robin rotation with all three variable requesters active on an empty table.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            logic [2:0] exp_ack;
            exp_ack = ~(3'b001 << (c % 3));
            drv(3'b111, 0, 0, 0, 3'b000, 1'b0);
            #4;
            chk($sformatf("rr%0d.var_ack_", c), 32'(var_ack_), 32'(exp_ack));
            chk($sformatf("rr%0d.wb_sel_", c),  32'(wb_sel_),  32'({exp_ack, 3'b111}));
            tick();
        end

        // A reserved slot blocks the variable requester, which wins the next free cycle.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drv((c == 0) ? 3'b011 : 3'b111, 0, 0, 5, (c >= 5) ? 3'b110 : 3'b111, 1'b0);
            #4;
            if (c == 0) chk("vres.iss_ack_", 32'(iss_ack_), 32'h3);
            if (c == 5) begin
                chk("vres5.var_ack_", 32'(var_ack_), 32'h7);
                chk("vres5.wb_sel_",  32'(wb_sel_),  32'h3b);
            end
            if (c == 6) begin
                chk("vres6.var_ack_", 32'(var_ack_), 32'h6);
                chk("vres6.wb_sel_",  32'(wb_sel_),  32'h37);
            end
            tick();
        end

        // Longest legal latency lands exactly DEPTH-1 cycles later.
        do_reset();
        drv(3'b101, 0, 4'(DEPTH - 1), 0, 3'b111, 1'b0);
        #4;
        chk("lmax.iss_ack_", 32'(iss_ack_), 32'h5);
        tick();
        for (int c = 1; c < DEPTH; c++) begin
            drv(3'b111, 0, 0, 0, 3'b111, 1'b0);
            #4;
            chk($sformatf("lmax%0d.wb_e_", c), 32'(wb_e_), (c == DEPTH - 1) ? 32'h0 : 32'h1);
            if (c == DEPTH - 1) chk("lmax.wb_sel_", 32'(wb_sel_), 32'h3d);
            tick();
        end

        // Port 0 keeps the bus booked every cycle while var 0 waits for a free slot.
        do_reset();
        drv(3'b110, 1, 0, 0, 3'b111, 1'b0);
        #4;
        chk("age.prime", 32'(iss_ack_), 32'h6);
        tick();
`ifdef WB_SCHED_AGING_EN
        for (int c = 0; c <= STARVE + 1; c++) begin
            drv(3'b110, 1, 0, 0, 3'b110, 1'b0);
            #4;
            chk($sformatf("age%0d.var_ack_", c), 32'(var_ack_), (c == STARVE + 1) ? 32'h6 : 32'h7);
            if (c <= STARVE)
                chk($sformatf("age%0d.iss_ack_", c), 32'(iss_ack_), (c == STARVE) ? 32'h7 : 32'h6);
            tick();
        end
`else
        for (int c = 0; c < 100; c++) begin
            drv(3'b110, 1, 0, 0, 3'b110, 1'b0);
            #4;
            chk($sformatf("noage%0d.var_ack_", c), 32'(var_ack_), 32'h7);
            chk($sformatf("noage%0d.iss_ack_", c), 32'(iss_ack_), 32'h6);
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
